// File: rtl/gf_sq_scale_pipe.sv
// Two-stage GF(2^WIDTH) pipeline: stage 1 optionally squares the operand,
// stage 2 optionally multiplies by a scale constant captured at acceptance.
module gf_sq_scale_pipe #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH:0]   POLY      = 5'h13,
    parameter logic [WIDTH-1:0] CONST_RST = 4'h9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [WIDTH-1:0] cfg_const,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    // Shift-and-add multiply with the reduction folded into every shift.
    function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] acc;
        logic [WIDTH-1:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < WIDTH; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = sh[WIDTH-1] ? ((sh << 1) ^ POLY[WIDTH-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

    logic             const_reg;
    logic [WIDTH-1:0] v_reg;
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;
    logic [WIDTH-1:0] s1_v_reg;
    logic             s1_scale_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;

    logic             s2_free;
    logic             accept;
    logic [WIDTH-1:0] s1_data_next;
    logic [WIDTH-1:0] s2_data_next;

    assign const_reg = 1'b0;

    // Stage 2 can take new data when empty or when its result leaves this cycle.
    assign s2_free  = !out_valid_reg || out_ready;
    assign in_ready = rst_n && (!s1_valid_reg || s2_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_data_next = in_mode[0] ? gf_mul(in_data, in_data) : in_data;
        s2_data_next = s1_scale_reg ? gf_mul(s1_data_reg, s1_v_reg) : s1_data_reg;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_reg         <= CONST_RST;
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            s1_v_reg      <= '0;
            s1_scale_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            if (cfg_we) v_reg <= cfg_const;

            if (s2_free) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) out_data_reg <= s2_data_next;
            end

            // The constant is sampled before this edge's cfg write lands.
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= s1_data_next;
                s1_v_reg     <= v_reg;
                s1_scale_reg <= in_mode[1];
            end else if (s2_free) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg && !const_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_gf_sq_scale_pipe.sv
// Self-checking bench: directed scenarios plus randomized traffic scored
// against a polynomial-arithmetic reference model.
module tb_gf_sq_scale_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, cfg_we, in_valid, in_ready, out_valid, out_ready;
    logic [3:0] cfg_const, in_data, out_data;
    logic [1:0] in_mode;

    logic       w8_rst_n, w8_cfg_we, w8_in_valid, w8_in_ready, w8_out_valid, w8_out_ready;
    logic [7:0] w8_cfg_const, w8_in_data, w8_out_data;
    logic [1:0] w8_in_mode;

    int checks = 0;
    int errors = 0;

    gf_sq_scale_pipe dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_const(cfg_const),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    gf_sq_scale_pipe #(.WIDTH(8), .POLY(9'h11B), .CONST_RST(8'h09)) dut8 (
        .clk(clk), .rst_n(w8_rst_n), .cfg_we(w8_cfg_we), .cfg_const(w8_cfg_const),
        .in_valid(w8_in_valid), .in_ready(w8_in_ready), .in_data(w8_in_data), .in_mode(w8_in_mode),
        .out_valid(w8_out_valid), .out_ready(w8_out_ready), .out_data(w8_out_data)
    );

    // Carry-less product followed by polynomial long division.
    function automatic int gf_ref(int a, int b, int w, int poly);
        int p = 0;
        for (int i = 0; i < w; i++)
            if (((b >> i) & 1) == 1) p = p ^ (a << i);
        for (int k = 2 * w - 2; k >= w; k--)
            if (((p >> k) & 1) == 1) p = p ^ (poly << (k - w));
        return p;
    endfunction

    function automatic int model(int x, int mode, int v, int w, int poly);
        int y = x;
        if ((mode & 1) != 0) y = gf_ref(x, x, w, poly);
        if ((mode & 2) != 0) y = gf_ref(y, v, w, poly);
        return y;
    endfunction

    function automatic int m4(int x, int mode, int v);
        return model(x, mode, v, 4, 'h13);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    // Single operand through an idle pipe with out_ready held high.
    task automatic run_one(input logic [3:0] x, input logic [1:0] mode,
                           input logic [3:0] exp, input string name);
        in_valid = 1'b1; in_data = x; in_mode = mode; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready got %b want 1", name, in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early got out_valid=%b want 0", name, out_valid);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp) begin
            errors++;
            $display("FAIL %s got valid=%b data=%h want valid=1 data=%h", name, out_valid, out_data, exp);
        end
        tick();
        $display("txn %s in=%h mode=%b out=%h exp=%h", name, x, mode, out_data, exp);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; in_data = 4'h7; in_mode = 2'b11;
        cfg_we = 1'b1; cfg_const = 4'h3; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 4'h0) begin
            errors++;
            $display("FAIL reset_state got ready=%b valid=%b data=%h want 0 0 0", in_ready, out_valid, out_data);
        end
        rst_n = 1'b1; in_valid = 1'b0; cfg_we = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release_ready got %b want 1", in_ready);
        end
        // v must still be the reset constant; cfg_we during reset was ignored.
        run_one(4'h2, 2'b11, 4'h2, "reset_v");
    endtask

    task automatic test_modes();
        run_one(4'h3, 2'b01, 4'h5, "square");
        cfg_we = 1'b1; cfg_const = 4'h8;
        tick();
        cfg_we = 1'b0;
        run_one(4'h8, 2'b10, 4'hC, "scale");
        run_one(4'hA, 2'b00, 4'hA, "pass");
        run_one(4'h5, 2'b11, 4'(m4(5, 3, 8)), "sq_scale_v8");
    endtask

    task automatic test_cfg_same_edge();
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 4'h2; in_mode = 2'b11; cfg_we = 1'b1; cfg_const = 4'h1;
        tick();
        cfg_we = 1'b0; in_data = 4'h2; in_mode = 2'b11;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h2) begin
            errors++; $display("FAIL cfg_old_v got valid=%b data=%h want 1 2", out_valid, out_data);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'h4) begin
            errors++; $display("FAIL cfg_new_v got valid=%b data=%h want 1 4", out_valid, out_data);
        end
        $display("txn cfg_same_edge results checked");
        tick();
    endtask

    task automatic test_backpressure();
        logic [3:0] xs [3];
        logic [1:0] ms [3];
        logic [3:0] ex [3];
        do_reset();
        for (int i = 0; i < 3; i++) begin
            xs[i] = 4'($urandom); ms[i] = 2'($urandom);
            ex[i] = 4'(m4(int'(xs[i]), int'(ms[i]), 9));
        end
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = xs[i]; in_mode = ms[i];
            #1;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL bp_accept%0d got %b want 1", i, in_ready);
            end
            tick();
        end
        in_valid = 1'b1; in_data = xs[2]; in_mode = ms[2];
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== ex[0]) begin
                errors++;
                $display("FAIL bp_hold%0d got ready=%b valid=%b data=%h want 0 1 %h", c, in_ready, out_valid, out_data, ex[0]);
            end
            tick();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== ex[k]) begin
                errors++;
                $display("FAIL bp_out%0d got valid=%b data=%h want 1 %h", k, out_valid, out_data, ex[k]);
            end
            if (k == 0) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL bp_release_ready got %b want 1", in_ready);
                end
            end
            $display("txn bp out%0d data=%h exp=%h", k, out_data, ex[k]);
            tick();
            in_valid = 1'b0;
        end
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] ex [8];
        do_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c < 8) begin
                in_valid = 1'b1; in_data = 4'($urandom); in_mode = 2'($urandom);
                ex[c] = 4'(m4(int'(in_data), int'(in_mode), 9));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++; $display("FAIL b2b_ready%0d got %b want 1", c, in_ready);
                end
            end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== ex[c-2]) begin
                    errors++;
                    $display("FAIL b2b_out%0d got valid=%b data=%h want 1 %h", c - 2, out_valid, out_data, ex[c-2]);
                end
                $display("txn b2b out%0d data=%h exp=%h", c - 2, out_data, ex[c-2]);
            end
            tick();
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cfg_we = 1'b1; cfg_const = 4'h5;
        tick();
        cfg_we = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 4'(i + 3); in_mode = 2'b11;
            tick();
        end
        rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b1; cfg_const = 4'h6;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_ready got %b want 0", in_ready);
        end
        tick();
        rst_n = 1'b1; cfg_we = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_data !== 4'h0) begin
                errors++;
                $display("FAIL midrst_stale%0d got valid=%b data=%h want 0 0", c, out_valid, out_data);
            end
            tick();
        end
        run_one(4'h2, 2'b11, 4'h2, "midrst_v");
    endtask

    task automatic test_random();
        int q[$];
        int v_model;
        bit acc, take;
        logic exp_ready;
        do_reset();
        v_model = 9;
        for (int c = 0; c < 600; c++) begin
            in_valid = 1'($urandom); in_data = 4'($urandom); in_mode = 2'($urandom);
            out_ready = (($urandom % 4) != 0);
            cfg_we = (($urandom % 8) == 0); cfg_const = 4'($urandom);
            #1;
            exp_ready = (q.size() < 2) || out_ready;
            checks++;
            if (in_ready !== exp_ready) begin
                errors++; $display("FAIL rand_ready cyc %0d got %b want %b", c, in_ready, exp_ready);
            end
            take = (out_valid === 1'b1) && out_ready;
            acc  = in_valid && (in_ready === 1'b1);
            if (take) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra cyc %0d got data=%h want no output", c, out_data);
                end else begin
                    int e = q.pop_front();
                    if (out_data !== 4'(e)) begin
                        errors++; $display("FAIL rand_data cyc %0d got %h want %h", c, out_data, 4'(e));
                    end
                end
            end
            if (acc) q.push_back(m4(int'(in_data), int'(in_mode), v_model));
            if (cfg_we) v_model = int'(cfg_const);
            tick();
        end
        in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (out_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_drain_extra got data=%h want no output", out_data);
                end else begin
                    int e = q.pop_front();
                    if (out_data !== 4'(e)) begin
                        errors++; $display("FAIL rand_drain got %h want %h", out_data, 4'(e));
                    end
                end
            end
            tick();
        end
        checks++;
        if (q.size() != 0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL rand_lost got pending=%0d valid=%b want 0 0", q.size(), out_valid);
        end
        $display("txn random traffic done, %0d checks so far", checks);
    endtask

    task automatic run_w8(input logic [7:0] x, input logic [1:0] mode,
                          input logic [7:0] exp, input string name);
        w8_in_valid = 1'b1; w8_in_data = x; w8_in_mode = mode; w8_out_ready = 1'b1;
        tick();
        w8_in_valid = 1'b0;
        #1;
        checks++;
        if (w8_out_valid !== 1'b0) begin
            errors++; $display("FAIL %s_early got valid=%b want 0", name, w8_out_valid);
        end
        tick();
        checks++;
        if (w8_out_valid !== 1'b1 || w8_out_data !== exp) begin
            errors++;
            $display("FAIL %s got valid=%b data=%h want 1 %h", name, w8_out_valid, w8_out_data, exp);
        end
        $display("txn %s in=%h mode=%b out=%h exp=%h", name, x, mode, w8_out_data, exp);
        tick();
    endtask

    task automatic test_width8();
        logic [7:0] v8;
        w8_rst_n = 1'b1;
        w8_cfg_we = 1'b1; w8_cfg_const = 8'h83;
        tick();
        w8_cfg_we = 1'b0;
        run_w8(8'h57, 2'b10, 8'hC1, "w8_scale");
        run_w8(8'h02, 2'b01, 8'h04, "w8_square");
        for (int i = 0; i < 12; i++) begin
            logic [7:0] x;
            logic [1:0] m;
            v8 = 8'($urandom); x = 8'($urandom); m = 2'($urandom);
            w8_cfg_we = 1'b1; w8_cfg_const = v8;
            tick();
            w8_cfg_we = 1'b0;
            run_w8(x, m, 8'(model(int'(x), int'(m), int'(v8), 8, 'h11B)), "w8_rand");
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_const = '0; in_valid = 1'b0;
        in_data = '0; in_mode = '0; out_ready = 1'b0;
        w8_rst_n = 1'b0; w8_cfg_we = 1'b0; w8_cfg_const = '0; w8_in_valid = 1'b0;
        w8_in_data = '0; w8_in_mode = '0; w8_out_ready = 1'b0;
        test_reset();
        test_modes();
        test_cfg_same_edge();
        test_backpressure();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
